// File: rtl/regbank_pkg.sv
// Shared sizing defaults and helpers for the regbank write-port logic.
// Pure declarations: no latency, no flow control.
// Pulled in by rr_arbiter and regbank_wport_arbiter.
package regbank_pkg;

    localparam int NUMREGS_DEF   = 32;
    localparam int DATAWIDTH_DEF = 32;

    // Clamped to 1 so single-entry configurations still get a legal vector width.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW_DEF = addr_w(NUMREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin from ptr, or lowest-index-wins with WPORT_FIXED_PRIO_EN.
// Latency: purely combinational, gnt follows req/ptr in the same cycle.
// Backpressure: at most one gnt bit set, none when req is empty.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = addr_w(N)
) (
    input  logic [N-1:0]  req,
`ifndef WPORT_FIXED_PRIO_EN
    input  logic [PW-1:0] ptr,
`endif
    output logic [N-1:0]  gnt
);

`ifdef WPORT_FIXED_PRIO_EN
    // Isolate the lowest set bit.
    always_comb begin
        gnt = req & (~req + N'(1));
    end
`else
    int   j_idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j_idx = 0;
        for (int i = 0; i < N; i++) begin
            j_idx = int'(ptr) + i;
            if (j_idx >= N) j_idx = j_idx - N;
            if (!found && req[j_idx]) begin
                gnt[j_idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regbank_wport_arbiter.sv
// Shares the regbank write port among NUMREQ writeback requesters and tracks pending writes.
// Latency: a transfer appears on we_o/waddr_o/wdata_o exactly one cycle later; 1 write/cycle.
// Backpressure: one-hot req_ready_o (RR, or fixed priority with WPORT_FIXED_PRIO_EN); 0 in reset.
module regbank_wport_arbiter
    import regbank_pkg::*;
#(
    parameter int NUMREQ    = 2,
    parameter int NUMREGS   = NUMREGS_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    localparam int AW = addr_w(NUMREGS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUMREQ-1:0]           req_valid_i,
    output logic [NUMREQ-1:0]           req_ready_o,
    input  logic [NUMREQ*AW-1:0]        req_addr_i,
    input  logic [NUMREQ*DATAWIDTH-1:0] req_data_i,
    output logic                        we_o,
    output logic [AW-1:0]               waddr_o,
    output logic [DATAWIDTH-1:0]        wdata_o,
    input  logic                        pend_set_i,
    input  logic [AW-1:0]               pend_addr_i,
    output logic [NUMREGS-1:0]          busy_o
);

    logic [NUMREQ-1:0]    gnt;
    logic                 xfer;
    logic [AW-1:0]        sel_addr;
    logic [DATAWIDTH-1:0] sel_data;
    logic [NUMREGS-1:0]   busy_q;
    logic [NUMREGS-1:0]   busy_d;

`ifndef WPORT_FIXED_PRIO_EN
    localparam int PW = addr_w(NUMREQ);
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] sel_idx;

    rr_arbiter #(.N(NUMREQ)) u_arb (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (gnt)
    );
`else
    rr_arbiter #(.N(NUMREQ)) u_arb (
        .req (req_valid_i),
        .gnt (gnt)
    );
`endif

    // Grants are masked during reset so in-flight requests are not consumed.
    assign req_ready_o = rst_i ? '0 : gnt;
    assign xfer        = |req_ready_o;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
`ifndef WPORT_FIXED_PRIO_EN
        sel_idx  = '0;
`endif
        for (int k = 0; k < NUMREQ; k++) begin
            if (gnt[k]) begin
                sel_addr = req_addr_i[k*AW +: AW];
                sel_data = req_data_i[k*DATAWIDTH +: DATAWIDTH];
`ifndef WPORT_FIXED_PRIO_EN
                sel_idx  = PW'(k);
`endif
            end
        end
    end

`ifndef WPORT_FIXED_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= (sel_idx == PW'(NUMREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end
`endif

    // Set is applied after clear so a re-issued destination stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (xfer)       busy_d[sel_addr]    = 1'b0;
        if (pend_set_i) busy_d[pend_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (xfer) begin
                we_o    <= (sel_addr != '0);
                waddr_o <= sel_addr;
                wdata_o <= sel_data;
            end else begin
                we_o    <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_regbank_wport_arbiter.sv
// Directed and random checks of regbank_wport_arbiter (NUMREQ=2, 32 regs, 32-bit data).
// Expectations follow the fixed-priority variant when WPORT_FIXED_PRIO_EN is defined.
module tb_regbank_wport_arbiter;

    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           pend_set;
    logic [AW-1:0]  pend_addr;
    logic [31:0]    busy;

    int checks = 0;
    int errors = 0;

    regbank_wport_arbiter #(.NUMREQ(NR), .NUMREGS(32), .DATAWIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .pend_set_i  (pend_set),
        .pend_addr_i (pend_addr),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    // Random-phase state
    logic [1:0]  m_vld;
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic [1:0]  e_gnt;
    int          m_ptr;
    int          g;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] m_busy;

    initial begin
        rst = 1'b1;
        pend_set = 1'b0;
        pend_addr = '0;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", waddr, 0);
        rst = 1'b0;

        // Contention: both valid four cycles
        drive(2'b11, 5'd5, 5'd7, 32'hA5, 32'hA7);
        #1;
        chk("t2_rdy0", req_ready, 2'b01);
        tick();
        chk("t2_we0", we, 1);
        chk("t2_waddr0", waddr, 5);
        chk("t2_wdata0", wdata, 32'hA5);
`ifdef WPORT_FIXED_PRIO_EN
        chk("t5_rdy1", req_ready, 2'b01);
        tick();
        chk("t5_waddr1", waddr, 5);
        chk("t5_rdy2", req_ready, 2'b01);
        tick();
        chk("t5_waddr2", waddr, 5);
        chk("t5_rdy3", req_ready, 2'b01);
        tick();
        chk("t5_waddr3", waddr, 5);
        chk("t5_wdata3", wdata, 32'hA5);
`else
        chk("t2_rdy1", req_ready, 2'b10);
        tick();
        chk("t2_waddr1", waddr, 7);
        chk("t2_wdata1", wdata, 32'hA7);
        chk("t2_rdy2", req_ready, 2'b01);
        tick();
        chk("t2_waddr2", waddr, 5);
        chk("t2_rdy3", req_ready, 2'b10);
        tick();
        chk("t2_we3", we, 1);
        chk("t2_waddr3", waddr, 7);
`endif

        // x0 write is accepted but not written
        drive(2'b10, 5'd0, 5'd0, 32'h0, 32'hFF);
        #1;
        chk("t3_rdy_x0", req_ready, 2'b10);
        tick();
        chk("t3_we_x0", we, 0);
        drive(2'b10, 5'd0, 5'd3, 32'h0, 32'h33);
        #1;
        chk("t3_rdy3", req_ready, 2'b10);
        tick();
        chk("t3_we3", we, 1);
        chk("t3_waddr3", waddr, 3);
        chk("t3_wdata3", wdata, 32'h33);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        chk("t3_idle_we", we, 0);
        chk("t3_hold_waddr", waddr, 3);
        chk("t3_hold_wdata", wdata, 32'h33);

        // Scoreboard
        pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        pend_set = 1'b0;
        chk("t4_set9", busy, 32'h0000_0200);
        drive(2'b01, 5'd9, 5'd0, 32'h99, 32'h0);
        tick();
        chk("t4_clr_we", we, 1);
        chk("t4_clr9", busy, 32'h0);
        pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        chk("t4_both_we", we, 1);
        chk("t4_set_wins", busy, 32'h0000_0200);
        pend_addr = 5'd0;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        pend_set = 1'b0;
        chk("t4_x0_busy", busy, 32'h0000_0200);

        // Reset mid-traffic; pointer is 1 here in round-robin mode
        drive(2'b11, 5'd5, 5'd7, 32'hA5, 32'hA7);
        #1;
`ifdef WPORT_FIXED_PRIO_EN
        chk("t1_pre_rdy", req_ready, 2'b01);
`else
        chk("t1_pre_rdy", req_ready, 2'b10);
`endif
        rst = 1'b1;
        #1;
        chk("t1_rdy_in_rst", req_ready, 2'b00);
        tick();
        chk("t1_we", we, 0);
        chk("t1_busy", busy, 0);
        tick();
        chk("t1_rdy_in_rst2", req_ready, 2'b00);
        rst = 1'b0;
        #1;
        chk("t1_first_gnt", req_ready, 2'b01);
        tick();
        chk("t1_first_waddr", waddr, 5);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();

        // Random traffic against a reference model
        m_vld  = '0;
        m_ptr  = 0;
        m_busy = '0;
        e_waddr = waddr;
        e_wdata = wdata;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_vld[k] && ($urandom_range(0, 1) == 1)) begin
                    m_vld[k]  = 1'b1;
                    m_addr[k] = 5'($urandom_range(0, 31));
                    m_data[k] = $urandom;
                end
            end
            pend_set  = ($urandom_range(0, 2) == 0);
            pend_addr = 5'($urandom_range(0, 31));
            drive(m_vld, m_addr[0], m_addr[1], m_data[0], m_data[1]);
            #1;
            g = -1;
`ifdef WPORT_FIXED_PRIO_EN
            if (m_vld[0]) g = 0;
            else if (m_vld[1]) g = 1;
`else
            if (m_vld[m_ptr]) g = m_ptr;
            else if (m_vld[1 - m_ptr]) g = 1 - m_ptr;
`endif
            e_gnt = (g < 0) ? 2'b00 : 2'(1 << g);
            chk("rnd_rdy", req_ready, e_gnt);
            e_we = 1'b0;
            if (g >= 0) begin
                e_we    = (m_addr[g] != 0);
                e_waddr = m_addr[g];
                e_wdata = m_data[g];
                m_busy[m_addr[g]] = 1'b0;
                m_ptr = (g + 1) % 2;
            end
            if (pend_set) m_busy[pend_addr] = 1'b1;
            m_busy[0] = 1'b0;
            tick();
            chk("rnd_we", we, e_we);
            chk("rnd_waddr", waddr, e_waddr);
            chk("rnd_wdata", wdata, e_wdata);
            chk("rnd_busy", busy, m_busy);
            if (g >= 0) m_vld[g] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
